// File: rtl/lcd_bus_timing_ctrl.sv
// rtl/lcd_bus_timing_ctrl.sv - Avalon-MM slave sequencing timed HD44780 LCD bus cycles
module lcd_bus_timing_ctrl #(
    parameter int T_SETUP_CYC = 3,
    parameter int T_EPW_CYC   = 12,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_CYCLE_CYC = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] avs_address,
    input  logic       avs_read,
    input  logic       avs_write,
    input  logic [7:0] avs_writedata,
    output logic [7:0] avs_readdata,
    output logic       avs_waitrequest,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    inout  wire  [7:0] LCD_data
);

    localparam int RECOVER_CYC = T_CYCLE_CYC - (T_SETUP_CYC + T_EPW_CYC + T_HOLD_CYC);
    localparam bit HAS_RECOVER = (RECOVER_CYC > 0);

    localparam logic [7:0] SETUP_LAST   = 8'(T_SETUP_CYC - 1);
    localparam logic [7:0] EPW_LAST     = 8'(T_EPW_CYC - 1);
    localparam logic [7:0] HOLD_LAST    = 8'(T_HOLD_CYC - 1);
    localparam logic [7:0] RECOVER_LAST = 8'(HAS_RECOVER ? RECOVER_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_E_HIGH,
        S_HOLD,
        S_RECOVER
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] cnt;
    logic       state_last;
    logic       done;
    logic       drive;
    logic       is_read;
    logic [7:0] data_q;

    always_comb begin
        next_state = state;
        state_last = 1'b0;
        case (state)
            S_IDLE: begin
                if (avs_read || avs_write) next_state = S_SETUP;
            end
            S_SETUP: begin
                state_last = (cnt == SETUP_LAST);
                if (state_last) next_state = S_E_HIGH;
            end
            S_E_HIGH: begin
                state_last = (cnt == EPW_LAST);
                if (state_last) next_state = S_HOLD;
            end
            S_HOLD: begin
                state_last = (cnt == HOLD_LAST);
                if (state_last) next_state = HAS_RECOVER ? S_RECOVER : S_IDLE;
            end
            S_RECOVER: begin
                state_last = (cnt == RECOVER_LAST);
                if (state_last) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        done            = (state == S_HOLD) && state_last;
        avs_waitrequest = (avs_read || avs_write) && !done;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cnt          <= 8'd0;
            LCD_E        <= 1'b0;
            LCD_RS       <= 1'b0;
            LCD_RW       <= 1'b1;
            drive        <= 1'b0;
            is_read      <= 1'b0;
            data_q       <= 8'd0;
            avs_readdata <= 8'd0;
        end else begin
            state <= next_state;
            cnt   <= (next_state != state || state == S_IDLE) ? 8'd0 : cnt + 8'd1;
            LCD_E <= (next_state == S_E_HIGH);

            // A simultaneous read and write is served as a write.
            if (state == S_IDLE && next_state == S_SETUP) begin
                LCD_RS  <= avs_address[1];
                LCD_RW  <= avs_write ? 1'b0 : avs_address[0];
                drive   <= avs_write;
                is_read <= !avs_write;
                data_q  <= avs_writedata;
            end

            if (done) begin
                LCD_RW <= 1'b1;
                drive  <= 1'b0;
            end

            if (state == S_E_HIGH && state_last && is_read) avs_readdata <= LCD_data;
        end
    end

    // Gating on LCD_RW keeps the pins from fighting the panel whenever it may drive.
    assign LCD_data = (drive && !LCD_RW) ? data_q : 8'bz;

endmodule

// File: tb/tb_lcd_bus_timing_ctrl.sv
// tb/tb_lcd_bus_timing_ctrl.sv - randomized bench for lcd_bus_timing_ctrl against a cycle-window model
module tb_lcd_bus_timing_ctrl;

    localparam int S      = 3;
    localparam int EP     = 12;
    localparam int H      = 2;
    localparam int CYC0   = 25;
    localparam int CYC1   = 10;
    localparam int ACTIVE = S + EP + H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic [1:0]           rd_v;
    logic [1:0]           wr_v;
    logic [1:0][1:0]      addr_v;
    logic [1:0][7:0]      wdata_v;
    wire  [1:0][7:0]      rdata_v;
    wire  [1:0]           wreq_v;
    wire  [1:0]           e_v;
    wire  [1:0]           rs_v;
    wire  [1:0]           rw_v;
    wire  [7:0]           bus0;
    wire  [7:0]           bus1;
    logic [1:0][7:0]      model_val;

    // The panel model drives the bus whenever the controller signals a read cycle.
    assign bus0 = rw_v[0] ? model_val[0] : 8'bz;
    assign bus1 = rw_v[1] ? model_val[1] : 8'bz;

    lcd_bus_timing_ctrl u0 (
        .clk(clk), .reset_n(reset_n), .avs_address(addr_v[0]), .avs_read(rd_v[0]),
        .avs_write(wr_v[0]), .avs_writedata(wdata_v[0]), .avs_readdata(rdata_v[0]),
        .avs_waitrequest(wreq_v[0]), .LCD_E(e_v[0]), .LCD_RS(rs_v[0]), .LCD_RW(rw_v[0]),
        .LCD_data(bus0)
    );

    lcd_bus_timing_ctrl #(.T_CYCLE_CYC(CYC1)) u1 (
        .clk(clk), .reset_n(reset_n), .avs_address(addr_v[1]), .avs_read(rd_v[1]),
        .avs_write(wr_v[1]), .avs_writedata(wdata_v[1]), .avs_readdata(rdata_v[1]),
        .avs_waitrequest(wreq_v[1]), .LCD_E(e_v[1]), .LCD_RS(rs_v[1]), .LCD_RW(rw_v[1]),
        .LCD_data(bus1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    int         cyc_param [2] = '{CYC0, CYC1};
    int         idle_at   [2];
    int         st_c0     [2];
    bit         st_rd     [2];
    bit         st_wr     [2];
    logic [1:0] st_addr   [2];
    logic [7:0] st_wdata  [2];
    logic [7:0] st_mval   [2];
    logic [7:0] st_prev_rd[2];
    logic       st_prev_rs[2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int busy_len(input int i);
        return (cyc_param[i] > ACTIVE) ? cyc_param[i] : ACTIVE;
    endfunction

    task automatic clear_model(input int i);
        st_c0[i]      = -1000;
        st_rd[i]      = 1'b0;
        st_wr[i]      = 1'b0;
        st_addr[i]    = 2'b00;
        st_wdata[i]   = 8'h00;
        st_mval[i]    = 8'h00;
        st_prev_rd[i] = 8'h00;
        st_prev_rs[i] = 1'b0;
    endtask

    // Expected pins follow from where the current cycle falls in the setup/pulse/hold windows.
    task automatic check_cycle(input int i, input bit req);
        int         k;
        logic       busy, e_exp, rw_exp, rs_exp;
        logic [7:0] bus_exp, rd_exp, bus_obs;
        k       = cyc - st_c0[i];
        busy    = (k >= 1) && (k <= ACTIVE);
        e_exp   = (k >= 1 + S) && (k <= S + EP);
        rw_exp  = busy ? (st_wr[i] ? 1'b0 : st_addr[i][0]) : 1'b1;
        rs_exp  = (k >= 1) ? st_addr[i][1] : st_prev_rs[i];
        bus_exp = rw_exp ? model_val[i] : st_wdata[i];
        rd_exp  = (st_rd[i] && !st_wr[i] && k >= S + EP + 1) ? st_mval[i] : st_prev_rd[i];
        bus_obs = (i == 0) ? bus0 : bus1;
        check_eq($sformatf("u%0d_E k=%0d", i, k), e_v[i], e_exp);
        check_eq($sformatf("u%0d_RW k=%0d", i, k), rw_v[i], rw_exp);
        check_eq($sformatf("u%0d_RS k=%0d", i, k), rs_v[i], rs_exp);
        check_eq($sformatf("u%0d_BUS k=%0d", i, k), bus_obs, bus_exp);
        check_eq($sformatf("u%0d_RDATA k=%0d", i, k), rdata_v[i], rd_exp);
        check_eq($sformatf("u%0d_WAIT k=%0d", i, k), wreq_v[i], req && (k != ACTIVE));
    endtask

    task automatic idle_cycles(input int i, input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            check_cycle(i, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_mid(input int i);
        logic [7:0] bus_obs;
        #2 reset_n = 1'b0;
        #1;
        bus_obs = (i == 0) ? bus0 : bus1;
        check_eq("rst_E", e_v[i], 1'b0);
        check_eq("rst_RW", rw_v[i], 1'b1);
        check_eq("rst_RS", rs_v[i], 1'b0);
        check_eq("rst_BUS", bus_obs, model_val[i]);
        check_eq("rst_RDATA", rdata_v[i], 8'h00);
        check_eq("rst_WAIT", wreq_v[i], 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        rd_v    = '0;
        wr_v    = '0;
        clear_model(0);
        clear_model(1);
        @(posedge clk);
        #1;
        idle_at[0] = cyc;
        idle_at[1] = cyc;
    endtask

    // Called #1 after a clock edge; the request is held until waitrequest is expected low.
    task automatic xfer(input int i, input bit rd, input bit wr, input logic [1:0] addr,
                        input logic [7:0] wdata, input logic [7:0] mval, input int abort_k);
        int r, c0, t;
        st_prev_rs[i] = st_addr[i][1];
        st_prev_rd[i] = (st_rd[i] && !st_wr[i]) ? st_mval[i] : st_prev_rd[i];
        r  = cyc;
        c0 = (idle_at[i] > r) ? idle_at[i] : r;
        st_c0[i]    = c0;
        st_rd[i]    = rd;
        st_wr[i]    = wr;
        st_addr[i]  = addr;
        st_wdata[i] = wdata;
        st_mval[i]  = mval;
        model_val[i] = mval;
        rd_v[i]    = rd;
        wr_v[i]    = wr;
        addr_v[i]  = addr;
        wdata_v[i] = wdata;
        for (int n = 0; n < 200; n++) begin
            if (abort_k >= 0 && cyc == c0 + abort_k) begin
                reset_mid(i);
                return;
            end
            @(negedge clk);
            check_cycle(i, 1'b1);
            t = cyc;
            @(posedge clk);
            #1;
            if (t == c0 + ACTIVE) break;
        end
        rd_v[i] = 1'b0;
        wr_v[i] = 1'b0;
        idle_at[i] = c0 + 1 + busy_len(i);
    endtask

    task automatic random_xfers(input int i, input int n);
        int         kind;
        logic [1:0] addr;
        for (int j = 0; j < n; j++) begin
            kind = int'($urandom_range(0, 2));
            addr = 2'($urandom);
            if (kind == 1) addr[0] = 1'b1;
            idle_cycles(i, int'($urandom_range(0, 3)));
            xfer(i, kind != 0, kind != 1, addr, 8'($urandom), 8'($urandom), -1);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        rd_v      = '0;
        wr_v      = '0;
        addr_v    = '0;
        wdata_v   = '0;
        model_val = '0;
        clear_model(0);
        clear_model(1);
        repeat (2) @(posedge clk);
        #1;
        idle_cycles(0, 1);
        idle_cycles(1, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        idle_at[0] = cyc;
        idle_at[1] = cyc;

        xfer(0, 1'b0, 1'b1, 2'b10, 8'h41, 8'h80, -1);
        idle_cycles(0, 10);
        xfer(0, 1'b1, 1'b0, 2'b01, 8'h00, 8'h80, -1);
        idle_cycles(0, 10);
        xfer(0, 1'b0, 1'b1, 2'b00, 8'h38, 8'h80, -1);
        xfer(0, 1'b0, 1'b1, 2'b10, 8'h55, 8'h80, -1);
        idle_cycles(0, 10);
        xfer(0, 1'b1, 1'b1, 2'b01, 8'h0f, 8'h80, -1);
        random_xfers(0, 14);

        xfer(1, 1'b0, 1'b1, 2'b10, 8'h41, 8'h20, -1);
        xfer(1, 1'b0, 1'b1, 2'b00, 8'h01, 8'h20, -1);
        xfer(1, 1'b1, 1'b0, 2'b11, 8'h00, 8'hc7, -1);
        random_xfers(1, 14);

        idle_cycles(0, 30);
        xfer(0, 1'b1, 1'b0, 2'b01, 8'h00, 8'h5a, -1);
        idle_cycles(0, 10);
        xfer(0, 1'b0, 1'b1, 2'b10, 8'hc3, 8'h11, 8);
        idle_cycles(0, 2);
        xfer(0, 1'b0, 1'b1, 2'b10, 8'h6e, 8'h11, -1);
        xfer(0, 1'b1, 1'b0, 2'b11, 8'h00, 8'h9c, -1);
        idle_cycles(0, 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
